// File: rtl/tqvp_edge_pkg.sv
// Shared constants and helpers for the edge-capture front-end.
package tqvp_edge_pkg;

    localparam int NCH_DEF = 8;
    localparam int FW_DEF  = 4;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // True when an edge whose new level is new_lvl is reported under mode.
    function automatic logic edge_permitted(input logic [1:0] mode, input logic new_lvl);
        logic ok;
        case (mode)
            EDGE_OFF:  ok = 1'b0;
            EDGE_RISE: ok = new_lvl;
            EDGE_FALL: ok = ~new_lvl;
            EDGE_BOTH: ok = 1'b1;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tqvp_edge_filter_ch.sv
// One channel: stability-window glitch filter plus edge qualification.
module tqvp_edge_filter_ch
    import tqvp_edge_pkg::*;
#(
    parameter int FW = FW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          din,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [FW-1:0] filt_len,
    output logic          level,
    output logic          evt,
    output logic          evt_rise
);

    logic          primed_q, primed_d;
    logic          s_q, s_d;
    logic [FW-1:0] c_q, c_d;
    logic          evt_q, evt_d;
    logic          rise_q, rise_d;

    // Next-state: priming, disabled tracking, window counting and edge commit.
    always_comb begin
        primed_d = primed_q;
        s_d      = s_q;
        c_d      = c_q;
        evt_d    = 1'b0;
        rise_d   = 1'b0;
        if (clr) begin
            primed_d = 1'b0;
            s_d      = 1'b0;
            c_d      = '0;
        end else if (!primed_q) begin
            // First sample after reset/clear is taken as the baseline, no event.
            primed_d = 1'b1;
            s_d      = din;
            c_d      = '0;
        end else if (!en) begin
            s_d = din;
            c_d = '0;
        end else if (din == s_q) begin
            c_d = '0;
        end else if (c_q < filt_len) begin
            c_d = c_q + FW'(1);
        end else begin
            // ">=" so that shrinking filt_len mid-count commits immediately.
            s_d    = din;
            c_d    = '0;
            evt_d  = edge_permitted(mode, din);
            rise_d = edge_permitted(mode, din) & din;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed_q <= 1'b0;
            s_q      <= 1'b0;
            c_q      <= '0;
            evt_q    <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            primed_q <= primed_d;
            s_q      <= s_d;
            c_q      <= c_d;
            evt_q    <= evt_d;
            rise_q   <= rise_d;
        end
    end

    assign level    = s_q;
    assign evt      = evt_q;
    assign evt_rise = rise_q;

endmodule

// File: rtl/tqvp_edge_capture.sv
// Edge-capture front-end: NCH independent filter/edge channels.
module tqvp_edge_capture
    import tqvp_edge_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int FW  = FW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   ui_in,
    input  logic [NCH-1:0]   en,
    input  logic [2*NCH-1:0] edge_mode,
    input  logic [FW-1:0]    filt_len,
    input  logic             clr,
    output logic [NCH-1:0]   level,
    output logic [NCH-1:0]   evt,
    output logic [NCH-1:0]   evt_rise
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tqvp_edge_filter_ch #(.FW(FW)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .din      (ui_in[i]),
            .en       (en[i]),
            .mode     (edge_mode[2*i+1:2*i]),
            .filt_len (filt_len),
            .level    (level[i]),
            .evt      (evt[i]),
            .evt_rise (evt_rise[i])
        );
    end

endmodule

// File: tb/tb_tqvp_edge_capture.sv
// Directed self-checking bench for tqvp_edge_capture.
module tb_tqvp_edge_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ui_in;
    logic [7:0]  en;
    logic [15:0] edge_mode;
    logic [3:0]  filt_len;
    logic        clr;
    logic [7:0]  level;
    logic [7:0]  evt;
    logic [7:0]  evt_rise;

    int n_cmp  = 0;
    int n_fail = 0;

    tqvp_edge_capture dut (
        .clk       (clk),
        .rst       (rst),
        .ui_in     (ui_in),
        .en        (en),
        .edge_mode (edge_mode),
        .filt_len  (filt_len),
        .clr       (clr),
        .level     (level),
        .evt       (evt),
        .evt_rise  (evt_rise)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [7:0] lv, input logic [7:0] ev,
                        input logic [7:0] rs);
        chk({tag, ".level"}, level, lv);
        chk({tag, ".evt"}, evt, ev);
        chk({tag, ".evt_rise"}, evt_rise, rs);
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        ui_in     = 8'hFF;
        en        = 8'hFF;
        edge_mode = 16'hFFFF;
        filt_len  = 4'd0;
        tick(2);
        chk3("reset", 8'h00, 8'h00, 8'h00);

        // 1: priming gives level, never an event
        rst = 1'b0;
        tick(1);
        chk3("prime", 8'hFF, 8'h00, 8'h00);
        tick(1);
        chk3("prime_hold", 8'hFF, 8'h00, 8'h00);

        // filt_len=0: all channels fall in one clock, pulse is one cycle
        ui_in = 8'h00;
        tick(1);
        chk3("fall_all", 8'h00, 8'hFF, 8'h00);
        tick(1);
        chk3("fall_all_end", 8'h00, 8'h00, 8'h00);

        // 2: filt_len=3, ch0 rises, accepted 4 clocks later
        filt_len = 4'd3;
        ui_in    = 8'h01;
        tick(3);
        chk3("ch0_wait3", 8'h00, 8'h00, 8'h00);
        tick(1);
        chk3("ch0_commit", 8'h01, 8'h01, 8'h01);
        tick(1);
        chk3("ch0_pulse_end", 8'h01, 8'h00, 8'h00);

        // 3: 3-clock glitch on ch1 is discarded, counter restarts
        ui_in = 8'h03;
        tick(3);
        chk3("ch1_glitch", 8'h01, 8'h00, 8'h00);
        ui_in = 8'h01;
        tick(1);
        chk3("ch1_glitch_end", 8'h01, 8'h00, 8'h00);
        ui_in = 8'h03;
        tick(1);
        chk3("ch1_recount1", 8'h01, 8'h00, 8'h00);
        tick(2);
        chk3("ch1_recount3", 8'h01, 8'h00, 8'h00);
        ui_in = 8'h01;
        tick(1);
        chk3("ch1_back", 8'h01, 8'h00, 8'h00);

        // 4: ch2 rise-only with filt_len=0
        edge_mode = 16'hFFDF;
        filt_len  = 4'd0;
        ui_in     = 8'h05;
        tick(1);
        chk3("ch2_rise_a", 8'h05, 8'h04, 8'h04);
        ui_in = 8'h01;
        tick(1);
        chk3("ch2_fall_masked", 8'h01, 8'h00, 8'h00);
        ui_in = 8'h05;
        tick(1);
        chk3("ch2_rise_b", 8'h05, 8'h04, 8'h04);
        tick(1);
        chk3("ch2_rise_end", 8'h05, 8'h00, 8'h00);

        // 5: ch3 disabled tracks input, re-enable fires nothing
        en    = 8'hF7;
        ui_in = 8'h0D;
        tick(1);
        chk3("ch3_dis_hi", 8'h0D, 8'h00, 8'h00);
        ui_in = 8'h05;
        tick(1);
        chk3("ch3_dis_lo", 8'h05, 8'h00, 8'h00);
        ui_in = 8'h0D;
        tick(1);
        chk3("ch3_dis_hi2", 8'h0D, 8'h00, 8'h00);
        en = 8'hFF;
        tick(1);
        chk3("ch3_reen", 8'h0D, 8'h00, 8'h00);

        // 6: rst mid-count clears asynchronously, then re-primes
        filt_len = 4'd15;
        ui_in    = 8'h1D;
        tick(8);
        chk3("ch4_counting", 8'h0D, 8'h00, 8'h00);
        rst = 1'b1;
        #1;
        chk3("async_rst", 8'h00, 8'h00, 8'h00);
        tick(1);
        rst = 1'b0;
        tick(1);
        chk3("reprime", 8'h1D, 8'h00, 8'h00);
        tick(1);
        chk3("reprime_hold", 8'h1D, 8'h00, 8'h00);

        // synchronous clear behaves like reset, then primes without event
        clr = 1'b1;
        tick(1);
        chk3("clr", 8'h00, 8'h00, 8'h00);
        clr = 1'b0;
        tick(1);
        chk3("clr_reprime", 8'h1D, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
